// File: rtl/linear_layer_fifo_pkg.sv
// Shared types and elaboration helpers for the Linear_Layer start-token FIFO.
package linear_layer_fifo_pkg;

   // Occupancy state of the token FIFO.
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } occ_state_t;

   // Smallest read-address width able to index DEPTH slots (never below 1).
   function automatic int unsigned min_addr_width(input int unsigned depth);
      int unsigned w;
      w = 0;
      for (int i = 1; i < 32; i++) begin
         if ((w == 0) && ((32'd1 << i) >= depth)) begin
            w = 32'(i);
         end
      end
      return (w == 0) ? 32'd1 : w;
   endfunction

endpackage : linear_layer_fifo_pkg

// File: rtl/linear_layer_token_srl.sv
// Write-shift token storage: a push shifts every slot up by one and loads
// slot 0; the read port is a plain combinational mux on addr. No reset.
module linear_layer_token_srl
   import linear_layer_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Shift the whole array on a write; newest token enters at slot 0.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = int'(DEPTH) - 1; i > 0; i--) begin
            r_mem[i] <= r_mem[i-1];
         end
         r_mem[0] <= din;
      end
   end

   // Out-of-range addresses (only reachable while empty) read as zero.
   always_comb begin
      dout = '0;
      if (32'(addr) < DEPTH) begin
         dout = r_mem[addr];
      end
   end

endmodule : linear_layer_token_srl

// File: rtl/linear_layer_start_token_fifo.sv
// Consumer-side start-token FIFO: occupancy FSM, registered full/empty flags
// and read-pointer generation over a write-shift storage array (FWFT output).
module linear_layer_start_token_fifo
   import linear_layer_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   if_count
);

   localparam int unsigned CW = ADDR_WIDTH + 1;

   // Elaboration-time parameter sanity checks.
   if (DEPTH < 2) begin : g_bad_depth
      $error("linear_layer_start_token_fifo: DEPTH must be at least 2");
   end
   if (ADDR_WIDTH < min_addr_width(DEPTH)) begin : g_bad_addr_width
      $error("linear_layer_start_token_fifo: ADDR_WIDTH too small for DEPTH");
   end

   occ_state_t            r_state;
   occ_state_t            w_state_nxt;
   logic [CW-1:0]         r_count;
   logic [CW-1:0]         w_count_nxt;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
   logic                  r_empty_n;
   logic                  r_full_n;
   logic                  w_push;
   logic                  w_pop;

   // Accepted handshakes; the flags alone block illegal transfers.
   assign w_push = if_write & if_write_ce & r_full_n;
   assign w_pop  = if_read  & if_read_ce  & r_empty_n;

   // State, occupancy, pointer and flag registers.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state   <= ST_EMPTY;
         r_count   <= '0;
         r_rd_ptr  <= '1;
         r_empty_n <= 1'b0;
         r_full_n  <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_empty_n <= (w_count_nxt != '0);
         r_full_n  <= (w_count_nxt != CW'(DEPTH));
      end
   end

   // Next-state, occupancy and read pointer; push&pop in PARTIAL holds both.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_rd_ptr_nxt = r_rd_ptr;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_count_nxt  = CW'(1);
               w_rd_ptr_nxt = '0;
               w_state_nxt  = ST_PARTIAL;
            end
         end
         ST_PARTIAL: begin
            if (w_push && !w_pop) begin
               w_count_nxt  = r_count + CW'(1);
               w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(1);
               if (r_count == CW'(DEPTH - 1)) begin
                  w_state_nxt = ST_FULL;
               end
            end else if (w_pop && !w_push) begin
               w_count_nxt  = r_count - CW'(1);
               w_rd_ptr_nxt = r_rd_ptr - ADDR_WIDTH'(1);
               if (r_count == CW'(1)) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_count_nxt  = r_count - CW'(1);
               w_rd_ptr_nxt = r_rd_ptr - ADDR_WIDTH'(1);
               w_state_nxt  = ST_PARTIAL;
            end
         end
         default: begin
            w_state_nxt  = ST_EMPTY;
            w_count_nxt  = '0;
            w_rd_ptr_nxt = '1;
         end
      endcase
   end

   // Token storage, written on every accepted push, read at the oldest slot.
   linear_layer_token_srl #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_srl (
      .clk  (ap_clk),
      .we   (w_push),
      .addr (r_rd_ptr),
      .din  (if_din),
      .dout (if_dout)
   );

   assign if_full_n  = r_full_n;
   assign if_empty_n = r_empty_n;
   assign if_count   = r_count;

endmodule : linear_layer_start_token_fifo

// File: tb/tb_linear_layer_start_token_fifo.sv
// Directed bench for linear_layer_start_token_fifo (DEPTH=4, 1-bit tokens).
module tb_linear_layer_start_token_fifo;

   localparam int unsigned DATA_WIDTH = 1;
   localparam int unsigned ADDR_WIDTH = 2;
   localparam int unsigned DEPTH      = 4;

   logic                  ap_clk;
   logic                  ap_rst_n;
   logic                  if_write_ce;
   logic                  if_write;
   logic [DATA_WIDTH-1:0] if_din;
   logic                  if_full_n;
   logic                  if_read_ce;
   logic                  if_read;
   logic [DATA_WIDTH-1:0] if_dout;
   logic                  if_empty_n;
   logic [ADDR_WIDTH:0]   if_count;

   int n_vec;
   int n_err;

   linear_layer_start_token_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) dut (
      .ap_clk      (ap_clk),
      .ap_rst_n    (ap_rst_n),
      .if_write_ce (if_write_ce),
      .if_write    (if_write),
      .if_din      (if_din),
      .if_full_n   (if_full_n),
      .if_read_ce  (if_read_ce),
      .if_read     (if_read),
      .if_dout     (if_dout),
      .if_empty_n  (if_empty_n),
      .if_count    (if_count)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // Apply one cycle of stimulus, sample 1 time unit after the edge, go idle.
   task automatic cycle(input logic w, input logic wce, input logic d,
                        input logic r, input logic rce);
      if_write    = w;
      if_write_ce = wce;
      if_din      = d;
      if_read     = r;
      if_read_ce  = rce;
      @(posedge ap_clk);
      #1;
      if_write    = 1'b0;
      if_write_ce = 1'b0;
      if_din      = 1'b0;
      if_read     = 1'b0;
      if_read_ce  = 1'b0;
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      repeat (3) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      n_vec++;
      if ({if_empty_n, if_full_n, if_count} !== {1'b0, 1'b1, 3'd0}) begin
         n_err++;
         $display("FAIL reset_flags got empty_n=%0b full_n=%0b count=%0d want 0 1 0",
                  if_empty_n, if_full_n, if_count);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         n_vec++;
         if ({if_empty_n, if_full_n, if_count} !== {1'b0, 1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL idle_read[%0d] got empty_n=%0b full_n=%0b count=%0d want 0 1 0",
                     i, if_empty_n, if_full_n, if_count);
         end
      end
   endtask

   task automatic test_fill();
      logic [3:0] toks;
      toks = 4'b1101;  // bit i = i-th token pushed: 1,0,1,1
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b1, toks[i], 1'b0, 1'b0);
         n_vec++;
         if ({if_empty_n, if_full_n, if_count, if_dout} !==
             {1'b1, (i < 3), 3'(i + 1), 1'b1}) begin
            n_err++;
            $display("FAIL fill[%0d] got empty_n=%0b full_n=%0b count=%0d dout=%0b want 1 %0b %0d 1",
                     i, if_empty_n, if_full_n, if_count, if_dout, (i < 3), i + 1);
         end
      end
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_vec++;
      if ({if_full_n, if_count} !== {1'b0, 3'd4}) begin
         n_err++;
         $display("FAIL fill_overflow got full_n=%0b count=%0d want 0 4", if_full_n, if_count);
      end
   endtask

   task automatic test_drain();
      logic [3:0] toks;
      toks = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (if_dout !== toks[i]) begin
            n_err++;
            $display("FAIL drain_dout[%0d] got %0b want %0b", i, if_dout, toks[i]);
         end
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         n_vec++;
         if ({if_empty_n, if_full_n, if_count} !== {(i < 3), 1'b1, 3'(3 - i)}) begin
            n_err++;
            $display("FAIL drain[%0d] got empty_n=%0b full_n=%0b count=%0d want %0b 1 %0d",
                     i, if_empty_n, if_full_n, if_count, (i < 3), 3 - i);
         end
      end
   endtask

   task automatic test_push_pop();
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // A = 1
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // B = 0
      n_vec++;
      if ({if_count, if_dout} !== {3'd2, 1'b1}) begin
         n_err++;
         $display("FAIL pp_setup got count=%0d dout=%0b want 2 1", if_count, if_dout);
      end
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);  // push C = 1, pop A
      n_vec++;
      if ({if_count, if_dout, if_empty_n, if_full_n} !== {3'd2, 1'b0, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL pp_both got count=%0d dout=%0b empty_n=%0b full_n=%0b want 2 0 1 1",
                  if_count, if_dout, if_empty_n, if_full_n);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if ({if_count, if_dout} !== {3'd1, 1'b1}) begin
         n_err++;
         $display("FAIL pp_next got count=%0d dout=%0b want 1 1", if_count, if_dout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if ({if_count, if_empty_n} !== {3'd0, 1'b0}) begin
         n_err++;
         $display("FAIL pp_drain got count=%0d empty_n=%0b want 0 0", if_count, if_empty_n);
      end
   endtask

   task automatic test_full_write_pop();
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);  // write must be dropped while full
      n_vec++;
      if ({if_count, if_full_n} !== {3'd3, 1'b1}) begin
         n_err++;
         $display("FAIL full_wp got count=%0d full_n=%0b want 3 1", if_count, if_full_n);
      end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (if_dout !== 1'b0) begin
            n_err++;
            $display("FAIL full_wp_dout[%0d] got %0b want 0", i, if_dout);
         end
         cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      n_vec++;
      if ({if_count, if_empty_n} !== {3'd0, 1'b0}) begin
         n_err++;
         $display("FAIL full_wp_end got count=%0d empty_n=%0b want 0 0", if_count, if_empty_n);
      end
   endtask

   task automatic test_ce();
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if ({if_count, if_empty_n} !== {3'd0, 1'b0}) begin
         n_err++;
         $display("FAIL ce_write got count=%0d empty_n=%0b want 0 0", if_count, if_empty_n);
      end
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({if_count, if_empty_n, if_dout} !== {3'd1, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL ce_read got count=%0d empty_n=%0b dout=%0b want 1 1 1",
                  if_count, if_empty_n, if_dout);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      n_vec++;
      if (if_count !== 3'd3) begin
         n_err++;
         $display("FAIL arst_setup got count=%0d want 3", if_count);
      end
      #1;  // mid-cycle, well away from any clock edge
      ap_rst_n = 1'b0;
      #1;
      n_vec++;
      if ({if_empty_n, if_full_n, if_count} !== {1'b0, 1'b1, 3'd0}) begin
         n_err++;
         $display("FAIL arst got empty_n=%0b full_n=%0b count=%0d want 0 1 0",
                  if_empty_n, if_full_n, if_count);
      end
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if ({if_empty_n, if_count} !== {1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL arst_after got empty_n=%0b count=%0d want 0 0", if_empty_n, if_count);
      end
   endtask

   initial begin
      n_vec       = 0;
      n_err       = 0;
      ap_rst_n    = 1'b0;
      if_write    = 1'b0;
      if_write_ce = 1'b0;
      if_din      = 1'b0;
      if_read     = 1'b0;
      if_read_ce  = 1'b0;
      test_reset();
      test_fill();
      test_drain();
      test_push_pop();
      test_full_write_pop();
      test_ce();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_linear_layer_start_token_fifo

// File: doc/linear_layer_start_token_fifo.md
Name: linear_layer_start_token_fifo

Overview:
- Consumer-side start-token FIFO for the Linear_Layer dataflow region. It buffers start tokens from an upstream producer task and presents them to a downstream PE task.
- Owns the occupancy state machine, the full/empty handshake and the read-address generation for an internal write-shift storage array.
- The downstream side sees first-word-fall-through data selected by occupancy. It sits between a producer's start_write and a PE instance's start_full_n/start_empty_n pins.

Parameters:
- DATA_WIDTH, 1, token payload width in bits.
- ADDR_WIDTH, 2, read-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 4, number of token slots; minimum 2.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- if_write_ce  in  1  write-side clock enable; write is ignored when 0.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  token written on an accepted write.
- if_full_n  out  1  1 = at least one free slot.
- if_read_ce  in  1  read-side clock enable; read is ignored when 0.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  oldest stored token (FWFT).
- if_empty_n  out  1  1 = if_dout valid.
- if_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (ap_rst_n=0, async assert, sync deassert by the surrounding design): count=0, rd_ptr=all-ones (-1), if_empty_n=0, if_full_n=1, if_count=0.
  - Storage contents are not reset.
  - Reset mid-operation discards all tokens immediately.
- push = if_write & if_write_ce & if_full_n.
- pop = if_read & if_read_ce & if_empty_n.
- Storage on push: slot[i+1] <= slot[i] for all i, and slot[0] <= if_din.
- rd_ptr always points at the oldest token. if_dout = slot[rd_ptr] is combinational, with no extra latency.
- States: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY: push -> PARTIAL, or FULL if DEPTH=1 (DEPTH=1 is not allowed). pop is impossible because if_empty_n=0, so an if_read request is ignored.
  - PARTIAL: push only -> count+1, rd_ptr+1, becomes FULL at DEPTH. pop only -> count-1, rd_ptr-1, becomes EMPTY at 0. push&pop -> count and rd_ptr unchanged; the shift and the read happen in the same cycle. The next if_dout is the next-oldest token, because the shift moves it into rd_ptr.
  - FULL: push is impossible (if_full_n=0). pop -> PARTIAL. A simultaneous write request while FULL is dropped even if a pop occurs; there is no write-through-on-full.
- Flags are registered and updated in the same edge as count.
  - A token written at edge N is visible on if_dout with if_empty_n=1 after edge N, i.e. 1-cycle write-to-read latency.
  - if_full_n deasserts after the edge on which count reaches DEPTH.
  - if_full_n reasserts after the edge of the first pop from FULL.
- Invariants that must always hold:
  - if_empty_n == (count!=0)
  - if_full_n == (count!=DEPTH)
  - rd_ptr == count-1 (mod 2**ADDR_WIDTH)
- Occupancy never wraps. Illegal push/pop are blocked by the flags, never by count arithmetic.
- Width rules:
  - count is ADDR_WIDTH+1 bits.
  - rd_ptr is ADDR_WIDTH bits.
  - if_count = count, zero-extended as needed.

Decomposition:
- Shared package linear_layer_fifo_pkg holds:
  - a typedef for the 3-state occupancy enum (ST_EMPTY, ST_PARTIAL, ST_FULL);
  - a function computing the minimum ADDR_WIDTH for a given DEPTH, used for elaboration-time parameter checks.
- One sub-module: linear_layer_token_srl. It is the storage array with we/addr/din/dout and no reset. The controller above instantiates it with we=push and addr=rd_ptr.

Test Plan:
- Reset then idle: ap_rst_n low 3 cycles, then release -> if_empty_n=0, if_full_n=1, if_count=0; if_read=1 for 5 cycles changes nothing.
- Fill (DEPTH=4): push tokens 1,0,1,1 on consecutive cycles -> if_count 1..4, if_full_n=0 after the 4th edge; a 5th write with if_din=0 is dropped and if_count stays 4.
- Drain in order: from the full state 1,0,1,1, pop 4 cycles -> if_dout reads 1,0,1,1 oldest-first; if_empty_n=0 after the 4th pop; if_full_n=1 after the first pop.
- Simultaneous push/pop at count=2 holding A,B (A oldest), pushing C -> count stays 2; the popped value is A; the next if_dout is B, then C.
- Clock-enable gating: if_write=1, if_write_ce=0 -> no change; if_read=1, if_read_ce=0 with count=1 -> token retained and if_empty_n stays 1.
- Async reset mid-operation: with count=3, drop ap_rst_n between clock edges -> if_empty_n=0, if_full_n=1, if_count=0 immediately, with no clock edge required.
